pad_input_conditioner: RTL and testbench
========================================

# pad_input_conditioner

Conditions raw player push-button inputs into the clean `up`/`down` levels and periodic `timing_tick` strobe consumed by the player pad controller. Synchronises both asynchronous button lines to `clk`, debounces each with a stability counter, and generates a free-running single-cycle movement tick from a clock divider. One instance per player, sitting directly between the board pins and the pad controller.

## Interface
- `DEBOUNCE_CYCLES`, default 650000: consecutive stable cycles required before a debounced level changes (10 ms at 65 MHz); must be ≥ 2.
- `TICK_DIV`, default 1083333: `timing_tick` period in clock cycles (~60 Hz at 65 MHz); must be ≥ 2.
- `clk`  input  1  system clock (65 MHz pixel clock domain).
- `rst_n`  input  1  reset; asynchronous, active-low.
- `btn_up_raw`  input  1  raw up button, asynchronous to `clk`, active-high.
- `btn_down_raw`  input  1  raw down button, asynchronous to `clk`, active-high.
- `up`  output  1  debounced up request, registered level.
- `down`  output  1  debounced down request, registered level.
- `timing_tick`  output  1  single-cycle movement strobe, registered.

## Operation
- Synchroniser: per button, two flops in series; the second-stage output is the synced value `s`. Both stages reset to 0.
- Debouncer (per button, identical): state `db` (reset 0) and counter `cnt` of width $clog2(DEBOUNCE_CYCLES) (reset 0).
  - `s == db`: `cnt` ← 0, `db` holds.
  - `s != db` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
  - `s != db` and `cnt == DEBOUNCE_CYCLES-1`: `db` ← `s`, `cnt` ← 0.
  - Any single cycle with `s == db` during counting restarts the count from 0; glitches shorter than DEBOUNCE_CYCLES never reach `db`.
- Output stage: `up` ← `db_up`, `down` ← `db_down` (subject to Configuration), registered, reset 0.
- Tick generator: counter `tc` of width $clog2(TICK_DIV), reset 0; increments every cycle, wraps TICK_DIV-1 → 0. `timing_tick` ← 1 on the edge where `tc == TICK_DIV-1`, else 0. Runs continuously, independent of buttons.
- No state machine beyond the two debouncers and the divider; no handshake — the downstream controller samples levels on `timing_tick`.

## Timing
- Reset: `up`=0, `down`=0, `timing_tick`=0, all counters and sync flops 0, immediately on `rst_n` falling (asynchronous); release is synchronous to the next `clk` edge.
- Button latency: a raw level change held steady is reflected on `up`/`down` exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it (2 sync + DEBOUNCE_CYCLES debounce + 1 output register). Press and release latencies are identical.
- Tick: first `timing_tick` pulse is high during cycle TICK_DIV after reset release (edges counted from 1); thereafter exactly one high cycle every TICK_DIV cycles; never two consecutive high cycles.
- Simultaneous press: both debouncers run independently; simultaneous edges give simultaneous output changes.
- Reset mid-debounce: counter progress is discarded; outputs return to 0 with no pulse on release.
- Button held through reset: after release, output asserts DEBOUNCE_CYCLES+3 edges later, like a fresh press.

## Configuration
- `PAD_INPUT_MUTEX_EN` defined: when `db_up` and `db_down` are both 1, the output stage drives `up`=0 and `down`=0 (neither direction requested); single presses unaffected; latency unchanged.
- Not defined: `up`/`down` mirror `db_up`/`db_down` unconditionally, both may be 1 together (downstream cancels the motion).

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TICK_DIV=8.
- Reset: hold `rst_n`=0 with both buttons high for 10 cycles -> `up`=`down`=`timing_tick`=0 throughout; `rst_n` asserted mid-cycle clears outputs without waiting for `clk`.
- Clean press/release: `btn_up_raw` 0→1 held 20 cycles, then 1→0 -> `up` rises exactly 7 edges after first sampling edge, falls 7 edges after release; `down` stays 0.
- Glitch rejection: `btn_down_raw` high 3 cycles, low 1, high 3, low -> `down` never asserts; high 4+ cycles -> `down` asserts.
- Tick cadence: run 40 cycles after reset -> `timing_tick` high at cycles 8, 16, 24, 32, 40 only, each one cycle wide.
- Both pressed: both raw high simultaneously for 20 cycles -> with `PAD_INPUT_MUTEX_EN`, `up`=`down`=0 throughout; without it, both rise together on edge 7.
- Reset mid-debounce: press `btn_up_raw`, assert `rst_n`=0 at debounce count 2, release reset with button still high -> `up` rises 7 edges after reset release, not earlier.

Source files
------------

// File: rtl/pad_input_conditioner.sv
// Button conditioner: two-flop synchronisers, per-button stability debouncers and a free-running tick divider.
// Optional build macro PAD_INPUT_MUTEX_EN suppresses both outputs when up and down are debounced high together.
module pad_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int TICK_DIV        = 1083333
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic timing_tick
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TC_W  = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TICK_DIV - 1);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            db_q, db_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [TC_W-1:0]       tc_q, tc_d;
    logic                  up_q, up_d;
    logic                  down_q, down_d;
    logic                  tick_q, tick_d;

    // Next-state for synchronisers and debouncers.
    always_comb begin
        sync1_d = {btn_down_raw, btn_up_raw};
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = {CNT_W{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Output stage and tick divider next-state.
    always_comb begin
`ifdef PAD_INPUT_MUTEX_EN
        if (db_q[0] && db_q[1]) begin
            up_d   = 1'b0;
            down_d = 1'b0;
        end else begin
            up_d   = db_q[0];
            down_d = db_q[1];
        end
`else
        up_d   = db_q[0];
        down_d = db_q[1];
`endif
        if (tc_q == TC_LAST) begin
            tc_d = {TC_W{1'b0}};
        end else begin
            tc_d = tc_q + TC_W'(1);
        end
        tick_d = (tc_q == TC_LAST) ? 1'b1 : 1'b0;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            db_q    <= 2'b00;
            cnt_q   <= {(2*CNT_W){1'b0}};
            tc_q    <= {TC_W{1'b0}};
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            up_q    <= up_d;
            down_q  <= down_d;
            tick_q  <= tick_d;
        end
    end

    assign up          = up_q;
    assign down        = down_q;
    assign timing_tick = tick_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Scoreboard bench for pad_input_conditioner with DEBOUNCE_CYCLES=4, TICK_DIV=8.
module tb_pad_input_conditioner;

    localparam int DB = 4;
    localparam int TD = 8;
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_up_raw = 1'b0;
    logic btn_down_raw = 1'b0;
    logic up, down, timing_tick;

    pad_input_conditioner #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
        .up(up), .down(down), .timing_tick(timing_tick)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Expected events, encoded as cycle*2 + level.
    int q_up[$], q_down[$], q_tick[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output change or tick pulse is popped against the scoreboard.
    initial begin
        logic prev_up, prev_down;
        prev_up = 1'b0;
        prev_down = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_up", int'(up), 0);
                check("rst_down", int'(down), 0);
                check("rst_tick", int'(timing_tick), 0);
                prev_up = 1'b0;
                prev_down = 1'b0;
            end else begin
                if (up !== prev_up) begin
                    if (q_up.size() == 0) check("up_unexpected", cyc*2 + int'(up), -1);
                    else                  check("up_event", cyc*2 + int'(up), q_up.pop_front());
                    prev_up = up;
                end
                if (down !== prev_down) begin
                    if (q_down.size() == 0) check("down_unexpected", cyc*2 + int'(down), -1);
                    else                    check("down_event", cyc*2 + int'(down), q_down.pop_front());
                    prev_down = down;
                end
                if (timing_tick !== 1'b0) begin
                    if (q_tick.size() == 0) check("tick_unexpected", cyc*2 + 1, -1);
                    else                    check("tick_event", cyc*2 + int'(timing_tick), q_tick.pop_front());
                end
            end
        end
    end

    task automatic exp_up(input int c, input int v);
        q_up.push_back(c*2 + v);
    endtask

    task automatic exp_down(input int c, input int v);
        q_down.push_back(c*2 + v);
    endtask

    // Advance n cycles; the tick is expected on every multiple of TD since release.
    task automatic run(input int n);
        for (int c = cyc + 1; c <= cyc + n; c++) begin
            if (c % TD == 0) q_tick.push_back(c*2 + 1);
        end
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_up_missing"}, q_up.size(), 0);
        check({tag, "_down_missing"}, q_down.size(), 0);
        check({tag, "_tick_missing"}, q_tick.size(), 0);
        q_up.delete();
        q_down.delete();
        q_tick.delete();
    endtask

    task automatic reset_phase(input string tag, input logic u, input logic d);
        check_drained(tag);
        rst_n = 1'b0;
        btn_up_raw = u;
        btn_down_raw = d;
        repeat (10) begin
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        // Reset held with both buttons pressed, then tick cadence with idle buttons.
        reset_phase("init", 1'b1, 1'b1);
        btn_up_raw = 1'b0;
        btn_down_raw = 1'b0;
        run(40);

        // Clean press/release on up, then an asynchronous mid-cycle reset while up is high.
        reset_phase("tick", 1'b0, 1'b0);
        run(3);
        btn_up_raw = 1'b1; exp_up(cyc + LAT, 1);
        run(20);
        btn_up_raw = 1'b0; exp_up(cyc + LAT, 0);
        run(12);
        btn_up_raw = 1'b1; exp_up(cyc + LAT, 1);
        run(10);
        check("up_before_async_rst", int'(up), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_up", int'(up), 0);
        check("async_rst_down", int'(down), 0);

        // Glitch rejection on down: 3 high, 1 low, 3 high never reach the output.
        reset_phase("press", 1'b0, 1'b0);
        run(2);
        btn_down_raw = 1'b1; run(3);
        btn_down_raw = 1'b0; run(1);
        btn_down_raw = 1'b1; run(3);
        btn_down_raw = 1'b0; run(10);
        // Exactly DB cycles high is the shortest accepted press.
        c = cyc;
        btn_down_raw = 1'b1; exp_down(c + LAT, 1);
        run(DB);
        btn_down_raw = 1'b0; exp_down(c + DB + LAT, 0);
        run(14);

        // Both buttons pressed together.
        reset_phase("glitch", 1'b0, 1'b0);
        run(1);
        btn_up_raw = 1'b1;
        btn_down_raw = 1'b1;
`ifndef PAD_INPUT_MUTEX_EN
        exp_up(cyc + LAT, 1);
        exp_down(cyc + LAT, 1);
`endif
        run(20);
        btn_up_raw = 1'b0;
        btn_down_raw = 1'b0;
`ifndef PAD_INPUT_MUTEX_EN
        exp_up(cyc + LAT, 0);
        exp_down(cyc + LAT, 0);
`endif
        run(12);

        // Reset mid-debounce with the button held through reset.
        reset_phase("both", 1'b0, 1'b0);
        run(2);
        btn_up_raw = 1'b1;
        run(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("middb_rst_up", int'(up), 0);
        reset_phase("middb", 1'b1, 1'b0);
        exp_up(LAT, 1);
        run(12);

        check_drained("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
